// File: rtl/apb_per_bridge.sv
// APB4 slave to peripheral-interconnect master bridge: one registered request per APB
// access, optional wait for the write response, error propagation and a stall timeout.
module apb_per_bridge #(
  parameter int unsigned APB_ADDR_WIDTH  = 32,
  parameter int unsigned PER_ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned WRITE_WAIT_RESP = 0,
  parameter int unsigned TIMEOUT_CYCLES  = 0,
  localparam int unsigned BE_WIDTH       = DATA_WIDTH / 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0]     PWDATA,
  input  logic [BE_WIDTH-1:0]       PSTRB,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [DATA_WIDTH-1:0]     PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic                      per_master_req_o,
  output logic [PER_ADDR_WIDTH-1:0] per_master_add_o,
  output logic                      per_master_we_o,
  output logic [DATA_WIDTH-1:0]     per_master_wdata_o,
  output logic [BE_WIDTH-1:0]       per_master_be_o,
  input  logic                      per_master_gnt_i,
  input  logic                      per_master_r_valid_i,
  input  logic                      per_master_r_opc_i,
  input  logic [DATA_WIDTH-1:0]     per_master_r_rdata_i
);

  localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit          POSTED = (WRITE_WAIT_RESP == 0);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             drop_q;
  logic             access_c;
  logic             expire_c;

  // The counter spans REQ and RESP together; expiry is flagged on its last allowed cycle.
  always_comb begin
    access_c = PSEL && PENABLE;
    expire_c = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q            <= IDLE;
      cnt_q              <= '0;
      drop_q             <= 1'b0;
      PRDATA             <= '0;
      PREADY             <= 1'b0;
      PSLVERR            <= 1'b0;
      per_master_req_o   <= 1'b0;
      per_master_add_o   <= '0;
      per_master_we_o    <= 1'b0;
      per_master_wdata_o <= '0;
      per_master_be_o    <= '0;
    end else begin
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      // A response owed to a timed-out transfer is swallowed wherever it shows up.
      if (per_master_r_valid_i && drop_q) drop_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (access_c) begin
            per_master_add_o   <= PER_ADDR_WIDTH'(PADDR);
            per_master_we_o    <= PWRITE;
            per_master_wdata_o <= PWDATA;
            per_master_be_o    <= PWRITE ? PSTRB : '1;
            per_master_req_o   <= 1'b1;
            cnt_q              <= '0;
            state_q            <= REQ;
          end
        end
        REQ: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (per_master_gnt_i) begin
            per_master_req_o <= 1'b0;
            if (per_master_we_o && POSTED) begin
              PREADY  <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= RESP;
            end
          end else if (expire_c) begin
            per_master_req_o <= 1'b0;
            PREADY           <= 1'b1;
            PSLVERR          <= 1'b1;
            PRDATA           <= '0;
            state_q          <= DONE;
          end
        end
        RESP: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (per_master_r_valid_i && !drop_q) begin
            PRDATA  <= per_master_r_rdata_i;
            PSLVERR <= per_master_r_opc_i;
            PREADY  <= 1'b1;
            state_q <= DONE;
          end else if (expire_c) begin
            PRDATA  <= '0;
            PSLVERR <= 1'b1;
            PREADY  <= 1'b1;
            drop_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
